// File: rtl/wb_dual_port_ram_if.sv
// Bus bundle for the dual-port Wishbone RAM: both pipelined slave ports, A and B.
// Member names match the RAM's port list so the bench can address each bus signal directly.
interface wb_dual_port_ram_if #(
  parameter int DW = 32,
  parameter int AW = 10
);
  logic              i_a_cyc;
  logic              i_a_stb;
  logic              i_a_we;
  logic [AW-1:0]     i_a_addr;
  logic [DW-1:0]     i_a_data;
  logic [DW/8-1:0]   i_a_sel;
  logic              o_a_stall;
  logic              o_a_ack;
  logic              o_a_err;
  logic [DW-1:0]     o_a_data;

  logic              i_b_cyc;
  logic              i_b_stb;
  logic              i_b_we;
  logic [AW-1:0]     i_b_addr;
  logic [DW-1:0]     i_b_data;
  logic [DW/8-1:0]   i_b_sel;
  logic              o_b_stall;
  logic              o_b_ack;
  logic              o_b_err;
  logic [DW-1:0]     o_b_data;

  modport slave (
    input  i_a_cyc, i_a_stb, i_a_we, i_a_addr, i_a_data, i_a_sel,
    output o_a_stall, o_a_ack, o_a_err, o_a_data,
    input  i_b_cyc, i_b_stb, i_b_we, i_b_addr, i_b_data, i_b_sel,
    output o_b_stall, o_b_ack, o_b_err, o_b_data
  );

  modport master (
    output i_a_cyc, i_a_stb, i_a_we, i_a_addr, i_a_data, i_a_sel,
    input  o_a_stall, o_a_ack, o_a_err, o_a_data,
    output i_b_cyc, i_b_stb, i_b_we, i_b_addr, i_b_data, i_b_sel,
    input  o_b_stall, o_b_ack, o_b_err, o_b_data
  );
endinterface

// File: rtl/wb_dual_port_ram.sv
// Two Wishbone B4 pipelined slave ports sharing one DEPTH x DW memory, single-cycle response.
// Reads are read-first across ports; a same-address write collision stalls port B for one retry.
module wb_dual_port_ram #(
  parameter int DW    = 32,
  parameter int AW    = 10,
  parameter int DEPTH = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  wb_dual_port_ram_if.slave     bus
);
  localparam int             SW      = DW / 8;
  localparam int             IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]    DEPTH_L = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem_r [0:DEPTH-1];

  logic          a_req_s, a_in_range_s, a_acc_s, a_wr_s, a_rd_s, a_show_s;
  logic          b_req_s, b_in_range_s, b_acc_s, b_wr_s, b_rd_s, b_show_s;
  logic          collide_s;
  logic [IW-1:0] a_idx_s, b_idx_s;
  logic [DW-1:0] a_data_s, b_data_s;

  logic          a_ack_r, a_err_r, a_rd_ack_r;
  logic          b_ack_r, b_err_r, b_rd_ack_r;
  logic [DW-1:0] a_rdata_r, b_rdata_r;
  logic [DW-1:0] a_hold_r, b_hold_r;

  // Request decode, cross-port collision detection and read-data presentation
  always_comb begin
    a_req_s      = bus.i_a_cyc & bus.i_a_stb & ~i_reset;
    b_req_s      = bus.i_b_cyc & bus.i_b_stb & ~i_reset;
    a_in_range_s = ({1'b0, bus.i_a_addr} < DEPTH_L);
    b_in_range_s = ({1'b0, bus.i_b_addr} < DEPTH_L);
    a_idx_s      = bus.i_a_addr[IW-1:0];
    b_idx_s      = bus.i_b_addr[IW-1:0];
    // Port A wins a same-address write; B holds its request and retries next cycle
    collide_s    = a_req_s & b_req_s & bus.i_a_we & bus.i_b_we &
                   (bus.i_a_addr == bus.i_b_addr) & a_in_range_s;
    a_acc_s      = a_req_s;
    b_acc_s      = b_req_s & ~collide_s;
    a_wr_s       = a_acc_s & bus.i_a_we & a_in_range_s;
    b_wr_s       = b_acc_s & bus.i_b_we & b_in_range_s;
    a_rd_s       = a_acc_s & ~bus.i_a_we & a_in_range_s;
    b_rd_s       = b_acc_s & ~bus.i_b_we & b_in_range_s;
    // A read response dropped by cyc=0 leaves the previously presented data in place
    a_show_s     = a_rd_ack_r & bus.i_a_cyc;
    b_show_s     = b_rd_ack_r & bus.i_b_cyc;
    if (a_show_s) begin
      a_data_s = a_rdata_r;
    end else begin
      a_data_s = a_hold_r;
    end
    if (b_show_s) begin
      b_data_s = b_rdata_r;
    end else begin
      b_data_s = b_hold_r;
    end
  end

  // Memory array: byte-lane writes and read-first capture (reads see pre-write contents)
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < SW; i++) begin
      if (a_wr_s && bus.i_a_sel[i]) begin
        mem_r[a_idx_s][i*8 +: 8] <= bus.i_a_data[i*8 +: 8];
      end
      if (b_wr_s && bus.i_b_sel[i]) begin
        mem_r[b_idx_s][i*8 +: 8] <= bus.i_b_data[i*8 +: 8];
      end
    end
    if (a_rd_s) begin
      a_rdata_r <= mem_r[a_idx_s];
    end
    if (b_rd_s) begin
      b_rdata_r <= mem_r[b_idx_s];
    end
  end

  // Response pipeline and held read data; reset drops any in-flight response
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      a_ack_r    <= 1'b0;
      a_err_r    <= 1'b0;
      a_rd_ack_r <= 1'b0;
      a_hold_r   <= {DW{1'b0}};
      b_ack_r    <= 1'b0;
      b_err_r    <= 1'b0;
      b_rd_ack_r <= 1'b0;
      b_hold_r   <= {DW{1'b0}};
    end else begin
      a_ack_r    <= a_acc_s & a_in_range_s;
      a_err_r    <= a_acc_s & ~a_in_range_s;
      a_rd_ack_r <= a_rd_s;
      a_hold_r   <= a_data_s;
      b_ack_r    <= b_acc_s & b_in_range_s;
      b_err_r    <= b_acc_s & ~b_in_range_s;
      b_rd_ack_r <= b_rd_s;
      b_hold_r   <= b_data_s;
    end
  end

  assign bus.o_a_stall = 1'b0;
  assign bus.o_b_stall = collide_s;
  assign bus.o_a_ack   = a_ack_r & bus.i_a_cyc;
  assign bus.o_b_ack   = b_ack_r & bus.i_b_cyc;
  assign bus.o_a_err   = a_err_r & bus.i_a_cyc;
  assign bus.o_b_err   = b_err_r & bus.i_b_cyc;
  assign bus.o_a_data  = a_data_s;
  assign bus.o_b_data  = b_data_s;

endmodule

// File: tb/tb_wb_dual_port_ram.sv
// Bench for wb_dual_port_ram: directed scenarios plus randomized traffic on both ports,
// each cycle compared against an array-based memory model with one pending response per port.
module tb_wb_dual_port_ram;
  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 768;

  localparam int P_NONE = 0;
  localparam int P_WACK = 1;
  localparam int P_RACK = 2;
  localparam int P_ERR  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_dual_port_ram_if #(.DW(DW), .AW(AW)) bus ();

  wb_dual_port_ram #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] ref_mem [DEPTH];
  int          pend_a = P_NONE;
  int          pend_b = P_NONE;
  logic [31:0] pend_ra = 32'h0;
  logic [31:0] pend_rb = 32'h0;
  logic [31:0] exp_da  = 32'h0;
  logic [31:0] exp_db  = 32'h0;
  bit          b_stalled = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return r;
  endfunction

  function automatic int classify(input bit req, input logic we, input logic [AW-1:0] addr);
    if (!req) return P_NONE;
    if (int'(addr) >= DEPTH) return P_ERR;
    return we ? P_WACK : P_RACK;
  endfunction

  task automatic drive_a(input bit cyc, input bit stb, input bit we, input int addr,
                         input logic [31:0] d, input logic [3:0] sel);
    bus.i_a_cyc  = cyc;
    bus.i_a_stb  = stb;
    bus.i_a_we   = we;
    bus.i_a_addr = AW'(addr);
    bus.i_a_data = d;
    bus.i_a_sel  = sel;
  endtask

  task automatic drive_b(input bit cyc, input bit stb, input bit we, input int addr,
                         input logic [31:0] d, input logic [3:0] sel);
    bus.i_b_cyc  = cyc;
    bus.i_b_stb  = stb;
    bus.i_b_we   = we;
    bus.i_b_addr = AW'(addr);
    bus.i_b_data = d;
    bus.i_b_sel  = sel;
  endtask

  // Called shortly after a rising edge with this cycle's inputs driven: checks the cycle's
  // outputs against the model, then advances model and clock by one edge.
  task automatic step();
    bit a_req, b_req, stall_b, acc_b;
    #1;
    a_req   = bus.i_a_cyc && bus.i_a_stb;
    b_req   = bus.i_b_cyc && bus.i_b_stb;
    stall_b = a_req && b_req && bus.i_a_we && bus.i_b_we &&
              (bus.i_a_addr == bus.i_b_addr) && (int'(bus.i_a_addr) < DEPTH);
    if (pend_a == P_RACK && bus.i_a_cyc) exp_da = pend_ra;
    if (pend_b == P_RACK && bus.i_b_cyc) exp_db = pend_rb;
    check_eq("a_stall", bus.o_a_stall, 1'b0);
    check_eq("b_stall", bus.o_b_stall, stall_b);
    check_eq("a_ack", bus.o_a_ack, (pend_a == P_WACK || pend_a == P_RACK) && bus.i_a_cyc);
    check_eq("b_ack", bus.o_b_ack, (pend_b == P_WACK || pend_b == P_RACK) && bus.i_b_cyc);
    check_eq("a_err", bus.o_a_err, (pend_a == P_ERR) && bus.i_a_cyc);
    check_eq("b_err", bus.o_b_err, (pend_b == P_ERR) && bus.i_b_cyc);
    check_eq("a_data", bus.o_a_data, exp_da);
    check_eq("b_data", bus.o_b_data, exp_db);
    acc_b  = b_req && !stall_b;
    pend_a = classify(a_req, bus.i_a_we, bus.i_a_addr);
    pend_b = classify(acc_b, bus.i_b_we, bus.i_b_addr);
    if (pend_a == P_RACK) pend_ra = ref_mem[bus.i_a_addr];
    if (pend_b == P_RACK) pend_rb = ref_mem[bus.i_b_addr];
    if (pend_a == P_WACK)
      ref_mem[bus.i_a_addr] = merge(ref_mem[bus.i_a_addr], bus.i_a_data, bus.i_a_sel);
    if (pend_b == P_WACK)
      ref_mem[bus.i_b_addr] = merge(ref_mem[bus.i_b_addr], bus.i_b_data, bus.i_b_sel);
    b_stalled = stall_b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive_a(0, 0, 0, 0, 32'h0, 4'h0);
    drive_b(0, 0, 0, 0, 32'h0, 4'h0);
    rst = 1'b1;
    #2;
    check_eq("rst_a_ack", bus.o_a_ack, 1'b0);
    check_eq("rst_b_ack", bus.o_b_ack, 1'b0);
    check_eq("rst_a_err", bus.o_a_err, 1'b0);
    check_eq("rst_b_err", bus.o_b_err, 1'b0);
    check_eq("rst_a_data", bus.o_a_data, 32'h0);
    check_eq("rst_b_data", bus.o_b_data, 32'h0);
    check_eq("rst_a_stall", bus.o_a_stall, 1'b0);
    check_eq("rst_b_stall", bus.o_b_stall, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill every word so the model knows the whole memory
    drive_b(1, 0, 0, 0, 32'h0, 4'h0);
    for (int i = 0; i < DEPTH; i++) begin
      drive_a(1, 1, 1, i, $urandom, 4'hF);
      step();
    end

    // Full write on A, read back on B
    drive_a(1, 1, 1, 5, 32'hDEADBEEF, 4'hF);
    step();
    drive_a(1, 0, 0, 0, 32'h0, 4'h0);
    drive_b(1, 1, 0, 5, 32'h0, 4'h0);
    step();
    check_eq("r036_ack", bus.o_b_ack, 1'b1);
    check_eq("r036_data", bus.o_b_data, 32'hDEADBEEF);

    // Partial byte-lane write
    drive_b(1, 0, 0, 0, 32'h0, 4'h0);
    drive_a(1, 1, 1, 5, 32'h11223344, 4'h5);
    step();
    drive_a(1, 1, 0, 5, 32'h0, 4'h0);
    step();
    check_eq("r037_data", bus.o_a_data, 32'hDE22BE44);

    // Same-address write collision: A wins, B retries
    drive_a(1, 1, 1, 9, 32'hAAAA0000, 4'hF);
    drive_b(1, 1, 1, 9, 32'h0000BBBB, 4'hF);
    #1;
    check_eq("r038_stall", bus.o_b_stall, 1'b1);
    step();
    check_eq("r038_a_ack", bus.o_a_ack, 1'b1);
    check_eq("r038_b_noack", bus.o_b_ack, 1'b0);
    drive_a(1, 0, 0, 0, 32'h0, 4'h0);
    step();
    check_eq("r038_b_ack", bus.o_b_ack, 1'b1);
    drive_b(1, 1, 0, 9, 32'h0, 4'h0);
    step();
    check_eq("r038_final", bus.o_b_data, 32'h0000BBBB);

    // Cross-port read and write to one address: read-first
    drive_b(1, 0, 0, 0, 32'h0, 4'h0);
    drive_a(1, 1, 1, 3, 32'h1, 4'hF);
    step();
    drive_a(1, 1, 0, 3, 32'h0, 4'h0);
    drive_b(1, 1, 1, 3, 32'h2, 4'hF);
    step();
    check_eq("r039_old", bus.o_a_data, 32'h1);
    drive_b(1, 0, 0, 0, 32'h0, 4'h0);
    step();
    check_eq("r039_new", bus.o_a_data, 32'h2);

    // Out-of-range error, then a back-to-back burst
    drive_a(1, 1, 0, 800, 32'h0, 4'h0);
    step();
    check_eq("r040_err", bus.o_a_err, 1'b1);
    check_eq("r040_noack", bus.o_a_ack, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive_a(1, 1, 0, i, 32'h0, 4'h0);
      step();
      check_eq("r040_burst_ack", bus.o_a_ack, 1'b1);
    end

    // Dropped cyc: write still lands, read response is abandoned
    drive_a(1, 1, 1, 20, 32'hCAFEF00D, 4'hF);
    step();
    drive_a(0, 0, 0, 0, 32'h0, 4'h0);
    step();
    drive_a(1, 1, 0, 21, 32'h0, 4'h0);
    step();
    drive_a(0, 0, 0, 0, 32'h0, 4'h0);
    step();
    drive_a(1, 1, 0, 20, 32'h0, 4'h0);
    step();
    check_eq("cyc_drop_write", bus.o_a_data, 32'hCAFEF00D);

    // Reset with a read in flight
    drive_a(1, 1, 0, 9, 32'h0, 4'h0);
    step();
    rst = 1'b1;
    #1;
    check_eq("r041_a_ack", bus.o_a_ack, 1'b0);
    check_eq("r041_a_err", bus.o_a_err, 1'b0);
    check_eq("r041_a_data", bus.o_a_data, 32'h0);
    check_eq("r041_b_data", bus.o_b_data, 32'h0);
    drive_a(1, 1, 1, 9, 32'hFFFFFFFF, 4'hF);
    drive_b(1, 1, 1, 9, 32'hFFFFFFFF, 4'hF);
    #1;
    check_eq("r041_b_stall", bus.o_b_stall, 1'b0);
    pend_a = P_NONE;
    pend_b = P_NONE;
    exp_da = 32'h0;
    exp_db = 32'h0;
    b_stalled = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_a(1, 0, 0, 0, 32'h0, 4'h0);
    drive_b(1, 0, 0, 0, 32'h0, 4'h0);
    step();
    drive_a(1, 1, 0, 9, 32'h0, 4'h0);
    step();
    check_eq("r041_mem", bus.o_a_data, 32'h0000BBBB);

    // Randomized traffic on both ports
    for (int n = 0; n < 3000; n++) begin
      bit narrow;
      narrow = ($urandom_range(3) == 0);
      drive_a($urandom_range(15) != 0, $urandom_range(3) != 0, $urandom_range(1) == 1,
              narrow ? $urandom_range(7) : $urandom_range(799), $urandom, 4'($urandom));
      if (!b_stalled) begin
        drive_b($urandom_range(15) != 0, $urandom_range(3) != 0, $urandom_range(1) == 1,
                narrow ? $urandom_range(7) : $urandom_range(799), $urandom, 4'($urandom));
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_dual_port_ram.md
WB_DUAL_PORT_RAM -- requirements
Module: wb_dual_port_ram

Interface
REQ-001 SHALL have parameter DW, default 32: data width in bits; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter AW, default 10: word-address width in bits.
REQ-003 SHALL have parameter DEPTH, default 1024: number of words implemented, with 1 <= DEPTH <= 2^AW.
REQ-004 SHALL have port i_clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-005 SHALL have port i_reset, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have ports i_a_cyc and i_b_cyc, input, 1 bit each: Wishbone cycle for ports A and B.
REQ-007 SHALL have ports i_a_stb and i_b_stb, input, 1 bit each: request strobe.
REQ-008 SHALL have ports i_a_we and i_b_we, input, 1 bit each: 1 = write, 0 = read.
REQ-009 SHALL have ports i_a_addr and i_b_addr, input, AW bits each: word address.
REQ-010 SHALL have ports i_a_data and i_b_data, input, DW bits each: write data.
REQ-011 SHALL have ports i_a_sel and i_b_sel, input, DW/8 bits each: byte-lane write enables.
REQ-012 SHALL have ports o_a_stall and o_b_stall, output, 1 bit each: request not accepted this cycle.
REQ-013 SHALL have ports o_a_ack and o_b_ack, output, 1 bit each: request completed.
REQ-014 SHALL have ports o_a_err and o_b_err, output, 1 bit each: request failed.
REQ-015 SHALL have ports o_a_data and o_b_data, output, DW bits each: read data.

Function
REQ-016 SHALL implement two independent Wishbone B4 pipelined slave ports that share one DEPTH x DW memory.
REQ-017 SHALL accept a request on a port in a cycle where cyc=1, stb=1 and stall=0.
REQ-018 SHALL assert exactly one ack or err on a port in the cycle after each accepted request on that port; the port sustains 1 request/cycle.
REQ-019 SHALL, for an accepted read with addr < DEPTH, present mem[addr] on o_x_data together with ack.
REQ-020 SHALL hold o_x_data unchanged in every cycle without a read ack.
REQ-021 SHALL, for an accepted write with addr < DEPTH, update only the byte lanes whose sel bit is 1.
REQ-022 SHALL hold o_x_data unchanged on a write ack.
REQ-023 SHALL treat an accepted request with addr >= DEPTH as an error: err=1 the next cycle, ack=0, memory unmodified.
REQ-024 SHALL, on a read and a write to the same address in the same cycle (cross-port), return the pre-write data (read-first).
REQ-025 SHALL, when both ports request writes to the same in-range address in the same cycle, accept port A and assert o_b_stall combinationally in that cycle.
REQ-026 SHALL have port B retry on the next cycle with its held request, and SHALL not write port B data before port A's write.
REQ-027 SHALL never assert o_a_stall.
REQ-028 SHALL assert o_b_stall only under the collision condition of REQ-025.
REQ-029 SHALL suppress ack and err on a port if that port's cyc is 0 in the response cycle.
REQ-030 SHALL complete an in-flight write even when cyc is dropped, and SHALL abandon the response of an in-flight read.
REQ-031 SHALL ignore stb, and accept nothing, while cyc=0.

Reset
REQ-032 SHALL, while i_reset=1, immediately drive o_x_ack=0, o_x_err=0, o_x_data=0 and o_x_stall=0 on both ports.
REQ-033 SHALL discard any in-flight request on reset and generate no ack for it after reset releases.
REQ-034 SHALL NOT clear memory contents on reset.
REQ-035 SHALL accept requests from the first rising edge after i_reset deasserts.

Verification (DW=32, AW=10, DEPTH=768)
REQ-036 Write A addr 5 data 0xDEADBEEF sel 0xF, then read B addr 5 -> B ack 1 cycle later, o_b_data=0xDEADBEEF.
REQ-037 Write A addr 5 data 0x11223344 sel 0x5 over 0xDEADBEEF, then read -> 0xDE22BE44.
REQ-038 Same-cycle writes A addr 9 = 0xAAAA0000 and B addr 9 = 0x0000BBBB -> o_b_stall=1 for 1 cycle, A ack then B ack, final read = 0x0000BBBB.
REQ-039 Same-cycle read A addr 3 (holds 0x1) and write B addr 3 = 0x2 -> A returns 0x1, later read returns 0x2.
REQ-040 Read A addr 800 -> o_a_err=1 next cycle, ack=0; a back-to-back burst of 4 reads addr 0..3 -> 4 consecutive acks with correct data.
REQ-041 Assert i_reset while a read is in flight -> no ack; all outputs 0 asynchronously; memory retains 0x0000BBBB at addr 9.
